regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor of the single-write, two-read register file.
- Adds configurable data width, depth and read-port count, plus a second write port (ALU writeback and load writeback).
- Adds a per-register pending scoreboard for hazard detection, and a multi-cycle bulk-clear sequencer.
- Sits in the decode stage: read ports feed operand muxes; pending bits feed the hazard/stall unit.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, at least 4.
- ADDR_W, $clog2(DEPTH), register index width (derived).
- NUM_RD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, when 1, entry 0 is hardwired to zero and never pending.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rs_addr  in  [NUM_RD][ADDR_W]  read addresses
- o_rs_data  out  [NUM_RD][DATA_W]  read data, combinational
- o_rs_pending  out  [NUM_RD]  pending bit of each addressed register, combinational
- i_wr_en  in  [2]  write enables; index 0 = ALU writeback, index 1 = load writeback
- i_wr_addr  in  [2][ADDR_W]  write addresses
- i_wr_data  in  [2][DATA_W]  write data
- i_issue_valid  in  1  an instruction with a destination register issues this cycle
- i_issue_rd  in  ADDR_W  destination register of the issuing instruction
- i_clear  in  1  one-cycle request to zero all registers and pending bits
- o_clear_busy  out  1  clear sequence in progress
- o_clear_done  out  1  one-cycle pulse when the clear sequence finishes

Behaviour:
- Reset (synchronous, active-high):
  - All entries become 0 and all pending bits become 0 in one cycle.
  - The clear FSM goes to IDLE; o_clear_busy=0 and o_clear_done=0.
  - Reset overrides every other input, including a clear sequence in progress.
- Writes:
  - Take effect at the rising edge when i_wr_en[k]=1.
  - A write to entry 0 is dropped when ZERO_REG=1.
  - If both ports write the same address in the same cycle, port 1 wins.
- Reads (combinational, zero latency):
  - Priority order: (a) ZERO_REG=1 and addr==0 -> data 0, pending 0; (b) port 1 writing this addr -> i_wr_data[1]; (c) port 0 writing this addr -> i_wr_data[0]; (d) array contents.
  - The bypass applies to every read port independently.
- Scoreboard, one bit per entry:
  - i_issue_valid sets the bit for i_issue_rd.
  - Any enabled write port clears the bit for its address.
  - Set and clear on the same index in the same cycle: set wins, because the newer producer is outstanding.
  - Issue to entry 0 is ignored when ZERO_REG=1.
  - o_rs_pending reflects the registered state, after the bypass rule: a write this cycle to the addressed register forces o_rs_pending=0 unless an issue to the same register occurs in the same cycle.
- Clear FSM has two states, IDLE and CLEAR, with a counter idx of width ADDR_W:
  - IDLE: i_clear=1 -> go to CLEAR, idx=0, o_clear_busy=1 from the next cycle.
  - CLEAR: each cycle, entry[idx]=0 and pending[idx]=0, then idx increments.
  - When idx==DEPTH-1 and that entry is cleared -> go to IDLE and pulse o_clear_done for one cycle, on the cycle o_clear_busy drops.
  - Total busy time is DEPTH cycles.
  - During CLEAR: writes and issues are ignored; the bypass is disabled; reads return array contents; i_clear is ignored.
  - Counter wrap: idx must not wrap past DEPTH-1; the FSM leaves CLEAR instead.
- All outputs not listed above are combinational from state and inputs; there are no X outputs after reset.

Decomposition:
- Package regfile_pkg:
  - clear-state enum (CLR_IDLE, CLR_RUN)
  - constants WR_ALU=0 and WR_LOAD=1 for write-port indices
  - default width and depth constants
- Sub-module regfile_scoreboard: the DEPTH-bit pending vector with its set/clear/flush logic, instantiated once.
- Storage, the bypass muxes and the clear FSM stay in regfile_mp.

Test Plan:
- Reset, then write port 0 addr 5 = 0xDEADBEEF; next cycle read port 0 addr 5 -> 0xDEADBEEF; read addr 0 -> 0.
- Same cycle: port 0 writes addr 7 = 0x11 and port 1 writes addr 7 = 0x22, with read addr 7:
  - the bypass shows 0x22 in that cycle;
  - the array holds 0x22 afterwards.
- Issue rd=3, then read addr 3 -> pending=1; write addr 3 -> pending=0 in that same cycle (bypass) and afterwards; issue and write to addr 3 in the same cycle -> pending stays 1.
- Fill entries 1..31 with nonzero values, pulse i_clear, with DEPTH=32:
  - o_clear_busy is high for exactly 32 cycles;
  - o_clear_done pulses once;
  - all reads return 0 and no pending bits are set;
  - a write to addr 4 mid-clear is ignored.
- Assert i_reset at clear cycle 10 -> next cycle FSM is IDLE, busy=0, done never pulses, all entries 0.
- NUM_RD=4, DEPTH=16, DATA_W=64, ZERO_REG=0:
  - write addr 0 = 0x1234_5678_9ABC_DEF0 -> readable on all 4 ports;
  - issue rd=0 -> pending=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multi-port register file
package regfile_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  localparam int WR_ALU  = 0;
  localparam int WR_LOAD = 1;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits for hazard detection
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_set_en,
  input  logic [ADDR_W-1:0]      i_set_idx,
  input  logic [1:0]             i_clr_en,
  input  logic [1:0][ADDR_W-1:0] i_clr_idx,
  input  logic                   i_flush_en,
  input  logic [ADDR_W-1:0]      i_flush_idx,
  output logic [DEPTH-1:0]       o_pending
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Writebacks retire producers; a new issue wins over a same-cycle retire.
  always_comb begin
    pend_d = pend_q;
    if (i_clr_en[WR_ALU])  pend_d[i_clr_idx[WR_ALU]]  = 1'b0;
    if (i_clr_en[WR_LOAD]) pend_d[i_clr_idx[WR_LOAD]] = 1'b0;
    if (i_set_en)          pend_d[i_set_idx]          = 1'b1;
    if (i_flush_en)        pend_d[i_flush_idx]        = 1'b0;
    if (ZERO_REG != 0)     pend_d[0]                  = 1'b0;
  end

  // Pending vector register, wiped in one cycle on reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign o_pending = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - dual-write, multi-read register file with scoreboard and bulk clear
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] o_rs_data,
  output logic [NUM_RD-1:0]             o_rs_pending,
  input  logic [1:0]                    i_wr_en,
  input  logic [1:0][ADDR_W-1:0]        i_wr_addr,
  input  logic [1:0][DATA_W-1:0]        i_wr_data,
  input  logic                          i_issue_valid,
  input  logic [ADDR_W-1:0]             i_issue_rd,
  input  logic                          i_clear,
  output logic                          o_clear_busy,
  output logic                          o_clear_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic              run;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [1:0]        wr_ok;
  logic              issue_ok;
  logic [DEPTH-1:0]  pending;

  assign run = (state_q == CLR_RUN);

  // Writes and issues only count outside a clear, and never touch a hardwired zero entry.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wr_ok[k] = i_wr_en[k] && !run && !(HAS_ZERO && (i_wr_addr[k] == '0));
    end
    issue_ok = i_issue_valid && !run && !(HAS_ZERO && (i_issue_rd == '0));
  end

  // Clear sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= CLR_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Clear sequencer next state: walk every index once, then report completion.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (i_clear) begin
          state_d = CLR_RUN;
          idx_d   = '0;
        end
      end
      CLR_RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = CLR_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // Clear sequencer outputs.
  always_comb begin
    o_clear_busy = run;
    o_clear_done = done_q;
  end

  // Storage: reset wipes all, clear wipes one entry per cycle, else load port wins a collision.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (run) begin
      mem_q[idx_q] <= '0;
    end else begin
      if (wr_ok[WR_ALU])  mem_q[i_wr_addr[WR_ALU]]  <= i_wr_data[WR_ALU];
      if (wr_ok[WR_LOAD]) mem_q[i_wr_addr[WR_LOAD]] <= i_wr_data[WR_LOAD];
    end
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set_en   (issue_ok),
    .i_set_idx  (i_issue_rd),
    .i_clr_en   (wr_ok),
    .i_clr_idx  (i_wr_addr),
    .i_flush_en (run),
    .i_flush_idx(idx_q),
    .o_pending  (pending)
  );

  // Read ports with same-cycle writeback forwarding, suppressed while clearing.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit0, hit1, iss;
    a    = '0;
    hit0 = 1'b0;
    hit1 = 1'b0;
    iss  = 1'b0;
    for (int r = 0; r < NUM_RD; r++) begin
      a               = i_rs_addr[r];
      hit0            = wr_ok[WR_ALU]  && (i_wr_addr[WR_ALU]  == a);
      hit1            = wr_ok[WR_LOAD] && (i_wr_addr[WR_LOAD] == a);
      iss             = issue_ok && (i_issue_rd == a);
      o_rs_data[r]    = mem_q[a];
      o_rs_pending[r] = pending[a];
      if (HAS_ZERO && (a == '0)) begin
        o_rs_data[r]    = '0;
        o_rs_pending[r] = 1'b0;
      end else if (!run) begin
        if (hit1)      o_rs_data[r] = i_wr_data[WR_LOAD];
        else if (hit0) o_rs_data[r] = i_wr_data[WR_ALU];
        if ((hit0 || hit1) && !iss) o_rs_pending[r] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;

  logic [1:0][4:0]  a_rs_addr;
  logic [1:0][31:0] a_rs_data;
  logic [1:0]       a_rs_pend;
  logic [1:0]       a_wr_en;
  logic [1:0][4:0]  a_wr_addr;
  logic [1:0][31:0] a_wr_data;
  logic             a_iv;
  logic [4:0]       a_rd;
  logic             a_clr, a_busy, a_done;

  logic [3:0][3:0]  b_rs_addr;
  logic [3:0][63:0] b_rs_data;
  logic [3:0]       b_rs_pend;
  logic [1:0]       b_wr_en;
  logic [1:0][3:0]  b_wr_addr;
  logic [1:0][63:0] b_wr_data;
  logic             b_iv;
  logic [3:0]       b_rd;
  logic             b_clr, b_busy, b_done;

  int total = 0;
  int bad   = 0;

  regfile_mp dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_rs_addr(a_rs_addr), .o_rs_data(a_rs_data), .o_rs_pending(a_rs_pend),
    .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
    .i_issue_valid(a_iv), .i_issue_rd(a_rd),
    .i_clear(a_clr), .o_clear_busy(a_busy), .o_clear_done(a_done)
  );

  regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(4), .ZERO_REG(0)) dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_rs_addr(b_rs_addr), .o_rs_data(b_rs_data), .o_rs_pending(b_rs_pend),
    .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
    .i_issue_valid(b_iv), .i_issue_rd(b_rd),
    .i_clear(b_clr), .o_clear_busy(b_busy), .o_clear_done(b_done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model for dut_a: register contents, outstanding producers, clear progress.
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_active = 1'b0;
  int          m_n = 0;
  bit          m_done = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  <= '0;
        m_pend[i] <= 1'b0;
      end
      m_active <= 1'b0;
      m_n      <= 0;
      m_done   <= 1'b0;
      m_valid  <= 1'b1;
    end else if (m_active) begin
      m_mem[m_n]  <= '0;
      m_pend[m_n] <= 1'b0;
      m_n         <= m_n + 1;
      m_done      <= (m_n == 31);
      m_active    <= (m_n != 31);
    end else begin
      m_done <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (a_wr_en[k] && a_wr_addr[k] != 5'd0) begin
          m_mem[a_wr_addr[k]]  <= a_wr_data[k];
          m_pend[a_wr_addr[k]] <= 1'b0;
        end
      end
      if (a_iv && a_rd != 5'd0) m_pend[a_rd] <= 1'b1;
      if (a_clr) begin
        m_active <= 1'b1;
        m_n      <= 0;
      end
    end
  end

  // Compare dut_a against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int r = 0; r < 2; r++) begin
        logic [4:0]  a;
        logic [31:0] ed;
        logic        ep, wr;
        a  = a_rs_addr[r];
        ed = m_mem[a];
        ep = m_pend[a];
        if (a == 5'd0) begin
          ed = '0;
          ep = 1'b0;
        end else if (!m_active) begin
          wr = 1'b0;
          if (a_wr_en[0] && a_wr_addr[0] == a) begin ed = a_wr_data[0]; wr = 1'b1; end
          if (a_wr_en[1] && a_wr_addr[1] == a) begin ed = a_wr_data[1]; wr = 1'b1; end
          if (wr && !(a_iv && a_rd == a)) ep = 1'b0;
        end
        chk($sformatf("model_data_p%0d@%0t", r, $time), 64'(a_rs_data[r]), 64'(ed));
        chk($sformatf("model_pend_p%0d@%0t", r, $time), 64'(a_rs_pend[r]), 64'(ep));
      end
      chk($sformatf("model_busy@%0t", $time), 64'(a_busy), 64'(m_active));
      chk($sformatf("model_done@%0t", $time), 64'(a_done), 64'(m_done));
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    #3;
  endtask

  initial begin
    int busy_n, done_n, done_at;
    rst = 1'b1;
    a_rs_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_iv = 1'b0; a_rd = '0; a_clr = 1'b0;
    b_rs_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_iv = 1'b0; b_rd = '0; b_clr = 1'b0;

    cyc; cyc;
    rst = 1'b0;
    a_rs_addr[0] = 5'd5;
    look;
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_data5", 64'(a_rs_data[0]), 64'd0);
    chk("rst_pend5", 64'(a_rs_pend[0]), 64'd0);
    chk("rst_b_pend", 64'(b_rs_pend), 64'd0);
    chk("rst_b_data", 64'(b_rs_data[0]), 64'd0);

    // single write then read back
    cyc;
    a_wr_en = 2'b01; a_wr_addr[0] = 5'd5; a_wr_data[0] = 32'hDEADBEEF;
    cyc;
    a_wr_en = 2'b00; a_rs_addr[0] = 5'd5; a_rs_addr[1] = 5'd0;
    look;
    chk("read5", 64'(a_rs_data[0]), 64'hDEADBEEF);
    chk("read0", 64'(a_rs_data[1]), 64'd0);

    // same-address collision: load port wins
    cyc;
    a_wr_en = 2'b11; a_wr_addr[0] = 5'd7; a_wr_addr[1] = 5'd7;
    a_wr_data[0] = 32'h11; a_wr_data[1] = 32'h22; a_rs_addr[0] = 5'd7;
    look;
    chk("bypass7", 64'(a_rs_data[0]), 64'h22);
    cyc;
    a_wr_en = 2'b00;
    look;
    chk("array7", 64'(a_rs_data[0]), 64'h22);

    // scoreboard set / clear / set-wins
    cyc;
    a_iv = 1'b1; a_rd = 5'd3;
    cyc;
    a_iv = 1'b0; a_rs_addr[0] = 5'd3;
    look;
    chk("pend3_set", 64'(a_rs_pend[0]), 64'd1);
    cyc;
    a_wr_en = 2'b01; a_wr_addr[0] = 5'd3; a_wr_data[0] = 32'h33;
    look;
    chk("pend3_bypass", 64'(a_rs_pend[0]), 64'd0);
    chk("data3_bypass", 64'(a_rs_data[0]), 64'h33);
    cyc;
    a_wr_en = 2'b00;
    look;
    chk("pend3_after_wr", 64'(a_rs_pend[0]), 64'd0);
    cyc;
    a_iv = 1'b1; a_rd = 5'd3;
    cyc;
    a_iv = 1'b0;
    look;
    chk("pend3_reissue", 64'(a_rs_pend[0]), 64'd1);
    cyc;
    a_iv = 1'b1; a_rd = 5'd3;
    a_wr_en = 2'b01; a_wr_addr[0] = 5'd3; a_wr_data[0] = 32'h44;
    look;
    chk("pend3_issue_and_wr", 64'(a_rs_pend[0]), 64'd1);
    cyc;
    a_iv = 1'b0; a_wr_en = 2'b00;
    look;
    chk("pend3_issue_wins", 64'(a_rs_pend[0]), 64'd1);
    chk("data3_after", 64'(a_rs_data[0]), 64'h44);

    // entry 0 stays zero and never pending
    cyc;
    a_iv = 1'b1; a_rd = 5'd0;
    a_wr_en = 2'b10; a_wr_addr[1] = 5'd0; a_wr_data[1] = 32'h55; a_rs_addr[1] = 5'd0;
    look;
    chk("zero_data_byp", 64'(a_rs_data[1]), 64'd0);
    chk("zero_pend_byp", 64'(a_rs_pend[1]), 64'd0);
    cyc;
    a_iv = 1'b0; a_wr_en = 2'b00;
    look;
    chk("zero_data", 64'(a_rs_data[1]), 64'd0);
    chk("zero_pend", 64'(a_rs_pend[1]), 64'd0);

    // fill 1..31, each with an outstanding producer
    for (int i = 1; i < 32; i++) begin
      cyc;
      a_wr_en = 2'b01; a_wr_addr[0] = 5'(i); a_wr_data[0] = 32'(i) * 32'h01010101;
      a_iv = 1'b1; a_rd = 5'(i);
    end
    cyc;
    a_wr_en = 2'b00; a_iv = 1'b0; a_rs_addr[0] = 5'd9;
    look;
    chk("fill9", 64'(a_rs_data[0]), 64'h09090909);
    chk("fill9_pend", 64'(a_rs_pend[0]), 64'd1);

    // bulk clear
    cyc;
    a_clr = 1'b1;
    cyc;
    a_clr = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin
        a_wr_en = 2'b01; a_wr_addr[0] = 5'd4; a_wr_data[0] = 32'hAA;
        a_iv = 1'b1; a_rd = 5'd4; a_clr = 1'b1;
        a_rs_addr[0] = 5'd4; a_rs_addr[1] = 5'd20;
      end
      if (c == 6) begin
        a_wr_en = 2'b00; a_iv = 1'b0; a_clr = 1'b0;
      end
      look;
      if (a_busy) busy_n++;
      if (a_done) begin
        done_n++;
        done_at = c;
      end
      if (c == 5) begin
        chk("clr_no_bypass4", 64'(a_rs_data[0]), 64'd0);
        chk("clr_not_yet20", 64'(a_rs_data[1]), 64'h14141414);
      end
      cyc;
    end
    chk("clr_busy_cycles", 64'(busy_n), 64'd32);
    chk("clr_done_count", 64'(done_n), 64'd1);
    chk("clr_done_cycle", 64'(done_at), 64'd32);
    for (int i = 0; i < 32; i++) begin
      a_rs_addr[0] = 5'(i);
      a_rs_addr[1] = 5'(31 - i);
      #1;
      chk($sformatf("clr_data%0d", i), 64'(a_rs_data[0]), 64'd0);
      chk($sformatf("clr_pend%0d", i), 64'(a_rs_pend[0]), 64'd0);
    end

    // reset in the middle of a clear
    cyc;
    a_wr_en = 2'b11; a_wr_addr[0] = 5'd1; a_wr_addr[1] = 5'd31;
    a_wr_data[0] = 32'hA1; a_wr_data[1] = 32'hB1;
    cyc;
    a_wr_en = 2'b00; a_clr = 1'b1;
    cyc;
    a_clr = 1'b0;
    for (int c = 0; c < 10; c++) cyc;
    look;
    chk("mid_busy", 64'(a_busy), 64'd1);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    a_rs_addr[0] = 5'd1; a_rs_addr[1] = 5'd31;
    look;
    chk("rstclr_busy", 64'(a_busy), 64'd0);
    chk("rstclr_done", 64'(a_done), 64'd0);
    chk("rstclr_data1", 64'(a_rs_data[0]), 64'd0);
    chk("rstclr_data31", 64'(a_rs_data[1]), 64'd0);
    done_n = 0;
    for (int c = 0; c < 40; c++) begin
      cyc;
      look;
      if (a_done) done_n++;
    end
    chk("rstclr_no_done", 64'(done_n), 64'd0);

    // wide, 4-port, no hardwired zero
    cyc;
    b_wr_en = 2'b01; b_wr_addr[0] = 4'd0; b_wr_data[0] = 64'h1234_5678_9ABC_DEF0;
    b_rs_addr = '0;
    look;
    chk("b_bypass0", b_rs_data[3], 64'h1234_5678_9ABC_DEF0);
    cyc;
    b_wr_en = 2'b00;
    look;
    for (int p = 0; p < 4; p++)
      chk($sformatf("b_data_p%0d", p), b_rs_data[p], 64'h1234_5678_9ABC_DEF0);
    cyc;
    b_iv = 1'b1; b_rd = 4'd0;
    cyc;
    b_iv = 1'b0;
    look;
    for (int p = 0; p < 4; p++)
      chk($sformatf("b_pend_p%0d", p), 64'(b_rs_pend[p]), 64'd1);

    cyc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
